// File: rtl/vend_credit_counter_if.sv
// Vending credit counter bus: coin/cancel inputs and
// credit/vend/change status outputs.
interface vend_credit_counter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             coin_a;
  logic             coin_b;
  logic             cancel;
  logic [WIDTH-1:0] credit;
  logic             vend;
  logic             change_pulse;
  logic             coin_reject;
  logic             busy;
  logic [CNT_W-1:0] vend_count;

  modport master (
    output coin_a, coin_b, cancel,
    input  credit, vend, change_pulse,
    input  coin_reject, busy, vend_count
  );

  modport slave (
    input  coin_a, coin_b, cancel,
    output credit, vend, change_pulse,
    output coin_reject, busy, vend_count
  );
endinterface

// File: rtl/vend_credit_counter.sv
// Credit accumulator and vend/refund controller
// for the vending machine.
module vend_credit_counter #(
  parameter int WIDTH       = 8,
  parameter int PRICE       = 15,
  parameter int COIN_A      = 5,
  parameter int COIN_B      = 10,
  parameter int CHANGE_UNIT = 5,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  vend_credit_counter_if.slave bus
);
  typedef enum logic [1:0] {
    COLLECT,
    VEND,
    REFUND
  } state_t;

  localparam int SW = WIDTH + 2;
  localparam logic [SW-1:0] MAXC =
    {2'b00, {WIDTH{1'b1}}};
  localparam logic [SW-1:0] CA = SW'(COIN_A);
  localparam logic [SW-1:0] CB = SW'(COIN_B);
  localparam logic [WIDTH-1:0] PR = WIDTH'(PRICE);
  localparam logic [WIDTH-1:0] CU =
    WIDTH'(CHANGE_UNIT);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] credit_q;
  logic [WIDTH-1:0] credit_nx;
  logic [CNT_W-1:0] vcnt_q;
  logic [CNT_W-1:0] vcnt_nx;
  logic             rej_q;
  logic             rej_nx;
  logic             coin;
  logic [SW-1:0]    sum;

  // State, credit, vend counter and reject flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      credit_q <= '0;
      vcnt_q   <= '0;
      rej_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      credit_q <= credit_nx;
      vcnt_q   <= vcnt_nx;
      rej_q    <= rej_nx;
    end
  end

  // Next-state, credit update and coin refusal
  always_comb begin
    state_nx  = state;
    credit_nx = credit_q;
    vcnt_nx   = vcnt_q;
    rej_nx    = 1'b0;
    coin      = bus.coin_a | bus.coin_b;
    sum       = {2'b00, credit_q}
              + (bus.coin_a ? CA : '0)
              + (bus.coin_b ? CB : '0);
    unique case (state)
      COLLECT: begin
        if (bus.cancel) begin
          rej_nx = coin;
          if (credit_q != '0) state_nx = REFUND;
        end else begin
          if (sum > MAXC) rej_nx = coin;
          else credit_nx = sum[WIDTH-1:0];
          if (credit_q >= PR) state_nx = VEND;
        end
      end
      VEND: begin
        rej_nx    = coin;
        credit_nx = credit_q - PR;
        vcnt_nx   = vcnt_q + CNT_W'(1);
        state_nx  = (credit_q > PR) ? REFUND : COLLECT;
      end
      REFUND: begin
        rej_nx = coin;
        if (credit_q >= CU) begin
          credit_nx = credit_q - CU;
          if (credit_q == CU) state_nx = COLLECT;
        end else begin
          credit_nx = '0;
          state_nx  = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  assign bus.credit       = credit_q;
  assign bus.vend         = (state == VEND);
  assign bus.change_pulse = (state == REFUND)
                          && (credit_q >= CU);
  assign bus.busy         = (state != COLLECT);
  assign bus.coin_reject  = rej_q;
  assign bus.vend_count   = vcnt_q;
endmodule
